// File: rtl/grid_rx_pkg.sv
// Shared constants and slot-timing helpers for the grid receive lane packer.
// Optional overflow counters are enabled with GRID_RX_OVFCNT_EN.
package grid_rx_pkg;

   localparam int DEF_LANE_W      = 4;
   localparam int DEF_PKT_BITS    = 128;
   localparam int DEF_HDR_BITS    = 8;
   localparam int DEF_SLOT_START  = 4;
   localparam int DEF_LINE_PERIOD = 40;

   function automatic int nslot(input int pkt_bits, input int lane_w);
      return pkt_bits / lane_w;
   endfunction

   function automatic int cap_end(input int slot_start, input int pkt_bits,
                                  input int lane_w);
      return slot_start + nslot(pkt_bits, lane_w) - 1;
   endfunction

   function automatic int commit_slot(input int slot_start, input int pkt_bits,
                                      input int lane_w);
      return cap_end(slot_start, pkt_bits, lane_w) + 2;
   endfunction

endpackage

// File: rtl/grid_rx_lane_slot.sv
// One lane: shift register, header test, output register, drop counter.
// The drop counter is built only with GRID_RX_OVFCNT_EN.
module grid_rx_lane_slot
   import grid_rx_pkg::*;
#(
   parameter int LANE_W   = DEF_LANE_W,
   parameter int PKT_BITS = DEF_PKT_BITS,
   parameter int HDR_BITS = DEF_HDR_BITS,
   parameter int OVF_W    = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                cap,
   input  logic                commit,
   input  logic                msb_first,
   input  logic [LANE_W-1:0]   lane,
   input  logic                ready,
   output logic                valid,
   output logic [PKT_BITS-1:0] dat,
   output logic                ovf,
   output logic [OVF_W-1:0]    ovf_cnt
);

   logic [PKT_BITS-1:0] sr;
   logic                hdr_nz;
   logic                do_commit;
   logic                take;

   assign hdr_nz    = |sr[PKT_BITS-1 -: HDR_BITS];
   assign do_commit = commit & hdr_nz;
   // A full slot may still take a new packet if it drains this cycle.
   assign take      = do_commit & (~valid | ready);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sr <= '0;
      end else if (cap) begin
         if (msb_first) sr <= {sr[PKT_BITS-LANE_W-1:0], lane};
         else           sr <= {lane, sr[PKT_BITS-1:LANE_W]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid <= 1'b0;
         dat   <= '0;
         ovf   <= 1'b0;
      end else begin
         ovf <= do_commit & valid & ~ready;
         if (take) begin
            valid <= 1'b1;
            dat   <= sr;
         end else if (valid & ready) begin
            valid <= 1'b0;
         end
      end
   end

`ifdef GRID_RX_OVFCNT_EN
   logic [OVF_W-1:0] cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                cnt <= '0;
      else if (ovf && cnt != '1)  cnt <= cnt + OVF_W'(1);
   end

   assign ovf_cnt = cnt;
`else
   assign ovf_cnt = '0;
`endif

endmodule

// File: rtl/grid_rx_lane_packer.sv
// Grid receive packet extractor: line-slot timing plus NCHANNELS lane slots.
// Define GRID_RX_OVFCNT_EN to build the per-channel drop counters.
module grid_rx_lane_packer
   import grid_rx_pkg::*;
#(
   parameter int NCHANNELS   = 9,
   parameter int LANE_W      = DEF_LANE_W,
   parameter int PKT_BITS    = DEF_PKT_BITS,
   parameter int HDR_BITS    = DEF_HDR_BITS,
   parameter int SLOT_START  = DEF_SLOT_START,
   parameter int LINE_PERIOD = DEF_LINE_PERIOD,
   parameter int OVF_W       = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          hsync_i,
   input  logic                          de_i,
   input  logic                          msb_first_i,
   input  logic [NCHANNELS*LANE_W-1:0]   dat_i,
   output logic [NCHANNELS-1:0]          pkt_valid_o,
   input  logic [NCHANNELS-1:0]          pkt_ready_i,
   output logic [NCHANNELS*PKT_BITS-1:0] pkt_dat_o,
   output logic [NCHANNELS-1:0]          ovf_o,
   output logic [NCHANNELS*OVF_W-1:0]    ovf_cnt_o
);

   localparam int CAP_END = cap_end(SLOT_START, PKT_BITS, LANE_W);
   localparam int COMMIT  = commit_slot(SLOT_START, PKT_BITS, LANE_W);
   localparam int CW      = $clog2(LINE_PERIOD);

   logic          hs_q;
   logic          hs_pe;
   logic [CW-1:0] cctr;
   logic          cap;
   logic          commit;

   assign hs_pe = hsync_i & ~hs_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hs_q <= 1'b0;
         cctr <= '0;
      end else begin
         hs_q <= hsync_i;
         if (hs_pe)
            cctr <= '0;
         else if (de_i)
            cctr <= (cctr == CW'(LINE_PERIOD-1)) ? '0 : cctr + CW'(1);
      end
   end

   assign cap    = de_i & ~hs_pe & (cctr >= CW'(SLOT_START))
                 & (cctr <= CW'(CAP_END));
   assign commit = de_i & ~hs_pe & (cctr == CW'(COMMIT));

   for (genvar n = 0; n < NCHANNELS; n++) begin : g_lane
      grid_rx_lane_slot #(
         .LANE_W   (LANE_W),
         .PKT_BITS (PKT_BITS),
         .HDR_BITS (HDR_BITS),
         .OVF_W    (OVF_W)
      ) u_slot (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .cap       (cap),
         .commit    (commit),
         .msb_first (msb_first_i),
         .lane      (dat_i[n*LANE_W +: LANE_W]),
         .ready     (pkt_ready_i[n]),
         .valid     (pkt_valid_o[n]),
         .dat       (pkt_dat_o[n*PKT_BITS +: PKT_BITS]),
         .ovf       (ovf_o[n]),
         .ovf_cnt   (ovf_cnt_o[n*OVF_W +: OVF_W])
      );
   end

endmodule

// File: tb/tb_grid_rx_lane_packer.sv
// Scoreboard bench for grid_rx_lane_packer at default parameters.
// Expected packets are queued per channel and popped on each handshake.
module tb_grid_rx_lane_packer;

   localparam int NCH = 9;
   localparam int LW  = 4;
   localparam int PB  = 128;
   localparam int OW  = 16;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic              hsync_i = 1'b0;
   logic              de_i = 1'b0;
   logic              msb_first_i = 1'b1;
   logic [NCH*LW-1:0] dat_i = '0;
   logic [NCH-1:0]    pkt_valid_o;
   logic [NCH-1:0]    pkt_ready_i = '1;
   logic [NCH*PB-1:0] pkt_dat_o;
   logic [NCH-1:0]    ovf_o;
   logic [NCH*OW-1:0] ovf_cnt_o;

   grid_rx_lane_packer dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .hsync_i     (hsync_i),
      .de_i        (de_i),
      .msb_first_i (msb_first_i),
      .dat_i       (dat_i),
      .pkt_valid_o (pkt_valid_o),
      .pkt_ready_i (pkt_ready_i),
      .pkt_dat_o   (pkt_dat_o),
      .ovf_o       (ovf_o),
      .ovf_cnt_o   (ovf_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int            vecs = 0;
   int            errs = 0;
   logic [PB-1:0] exp_q [NCH][$];
   int            exp_ovf [NCH];
   int            obs_ovf [NCH];
   logic [LW-1:0] beats [NCH][32];

   always @(negedge clk_i) begin
      if (rst_ni) begin
         for (int n = 0; n < NCH; n++) begin
            if (ovf_o[n]) obs_ovf[n]++;
            if (pkt_valid_o[n]) begin
               vecs++;
               if (exp_q[n].size() == 0) begin
                  errs++;
                  $display("FAIL unexpected_valid ch%0d got %h want none",
                           n, pkt_dat_o[n*PB +: PB]);
               end else begin
                  if (pkt_dat_o[n*PB +: PB] !== exp_q[n][0]) begin
                     errs++;
                     $display("FAIL pkt_dat ch%0d got %h want %h",
                              n, pkt_dat_o[n*PB +: PB], exp_q[n][0]);
                  end
                  if (pkt_ready_i[n]) void'(exp_q[n].pop_front());
               end
            end
         end
      end
   end

   task automatic fill_beats();
      for (int n = 0; n < NCH; n++)
         for (int b = 0; b < 32; b++)
            beats[n][b] = (n == 0) ? LW'(15 - (b % 16))
                                   : LW'($urandom_range(1, 15));
   endtask

   task automatic drive_line(input logic msb, input logic start,
                             input int abort_at, input logic chk_lat,
                             input logic [PB-1:0] lat_exp,
                             input logic rnd_rdy);
      logic [PB-1:0] pk;
      if (start) begin
         @(posedge clk_i); #1;
         hsync_i = 1'b1; de_i = 1'b1; dat_i = '0;
      end
      for (int s = 0; s < 40; s++) begin
         @(posedge clk_i); #1;
         if (s == abort_at) begin
            hsync_i = 1'b1;
            dat_i = '0;
            return;
         end
         hsync_i = 1'b0; de_i = 1'b1; msb_first_i = msb;
         if (rnd_rdy) pkt_ready_i = NCH'($urandom);
         for (int n = 0; n < NCH; n++)
            dat_i[n*LW +: LW] = (s >= 4 && s <= 35) ? beats[n][s-4]
                                                    : LW'($urandom);
         if (s == 37) begin
            if (chk_lat) begin
               vecs++;
               if (pkt_valid_o[0] !== 1'b0) begin
                  errs++;
                  $display("FAIL latency_early got %b want 0", pkt_valid_o[0]);
               end
            end
            for (int n = 0; n < NCH; n++) begin
               pk = '0;
               for (int b = 0; b < 32; b++)
                  pk = msb ? {pk[PB-LW-1:0], beats[n][b]}
                           : {beats[n][b], pk[PB-1:LW]};
               if (pk[PB-1 -: 8] != 8'h00) begin
                  if (exp_q[n].size() == 0 || pkt_ready_i[n])
                     exp_q[n].push_back(pk);
                  else
                     exp_ovf[n]++;
               end
            end
         end
         if (s == 38 && chk_lat) begin
            vecs++;
            if (pkt_valid_o[0] !== 1'b1 || pkt_dat_o[PB-1:0] !== lat_exp) begin
               errs++;
               $display("FAIL latency_pkt got v=%b %h want v=1 %h",
                        pkt_valid_o[0], pkt_dat_o[PB-1:0], lat_exp);
            end
         end
      end
      @(posedge clk_i); #1;
      de_i = 1'b0; hsync_i = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      logic empty;
      empty = 1'b0;
      for (int i = 0; i < 200 && !empty; i++) begin
         @(posedge clk_i); #1;
         empty = 1'b1;
         for (int n = 0; n < NCH; n++)
            if (exp_q[n].size() != 0) empty = 1'b0;
      end
      vecs++;
      if (!empty) begin
         errs++;
         $display("FAIL drain_%s got pending packets want none", name);
      end
   endtask

   task automatic check_zero_outputs(input string name);
      vecs++;
      if (pkt_valid_o !== '0) begin
         errs++;
         $display("FAIL %s_valid got %h want 0", name, pkt_valid_o);
      end
      vecs++;
      if (pkt_dat_o !== '0) begin
         errs++;
         $display("FAIL %s_dat got nonzero want 0", name);
      end
      vecs++;
      if (ovf_o !== '0) begin
         errs++;
         $display("FAIL %s_ovf got %h want 0", name, ovf_o);
      end
      vecs++;
      if (ovf_cnt_o !== '0) begin
         errs++;
         $display("FAIL %s_ovfcnt got %h want 0", name, ovf_cnt_o);
      end
   endtask

   task automatic test_reset();
      #1;
      check_zero_outputs("reset");
      vecs++;
      if (dut.cctr !== '0) begin
         errs++;
         $display("FAIL reset_cctr got %0d want 0", dut.cctr);
      end
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
   endtask

   task automatic test_msb_first();
      fill_beats();
      drive_line(1'b1, 1'b1, -1, 1'b1,
                 128'hFEDCBA9876543210FEDCBA9876543210, 1'b0);
      wait_drain("msb");
   endtask

   task automatic test_lsb_first();
      fill_beats();
      drive_line(1'b0, 1'b1, -1, 1'b1,
                 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
      wait_drain("lsb");
   endtask

   task automatic test_zero_header();
      fill_beats();
      beats[3][0] = '0;
      beats[3][1] = '0;
      drive_line(1'b1, 1'b1, -1, 1'b0, '0, 1'b0);
      wait_drain("zhdr");
      vecs++;
      if (obs_ovf[3] !== 0) begin
         errs++;
         $display("FAIL zhdr_ovf got %0d want 0", obs_ovf[3]);
      end
   endtask

   task automatic test_backpressure();
      logic [OW-1:0] want;
      pkt_ready_i = '1;
      pkt_ready_i[5] = 1'b0;
      fill_beats();
      drive_line(1'b1, 1'b1, -1, 1'b0, '0, 1'b0);
      fill_beats();
      drive_line(1'b1, 1'b1, -1, 1'b0, '0, 1'b0);
      repeat (3) @(posedge clk_i);
      #1;
      vecs++;
      if (obs_ovf[5] !== 1 || exp_ovf[5] !== 1) begin
         errs++;
         $display("FAIL bp_ovf got %0d model %0d want 1", obs_ovf[5], exp_ovf[5]);
      end
`ifdef GRID_RX_OVFCNT_EN
      want = OW'(1);
`else
      want = '0;
`endif
      vecs++;
      if (ovf_cnt_o[5*OW +: OW] !== want) begin
         errs++;
         $display("FAIL bp_ovfcnt got %0d want %0d", ovf_cnt_o[5*OW +: OW], want);
      end
      pkt_ready_i = '1;
      wait_drain("bp");
   endtask

   task automatic test_abort();
      fill_beats();
      drive_line(1'b1, 1'b1, 20, 1'b0, '0, 1'b0);
      @(posedge clk_i); #1;
      vecs++;
      if (dut.cctr !== '0) begin
         errs++;
         $display("FAIL abort_cctr got %0d want 0", dut.cctr);
      end
      de_i = 1'b0; hsync_i = 1'b0;
      repeat (45) @(posedge clk_i);
      fill_beats();
      drive_line(1'b1, 1'b1, -1, 1'b0, '0, 1'b0);
      wait_drain("abort");
   endtask

   task automatic test_back_to_back();
      for (int l = 0; l < 4; l++) begin
         fill_beats();
         drive_line(1'($urandom), 1'b1, -1, 1'b0, '0, 1'b1);
      end
      pkt_ready_i = '1;
      wait_drain("b2b");
   endtask

   task automatic test_reset_mid();
      pkt_ready_i = '0;
      fill_beats();
      drive_line(1'b1, 1'b1, -1, 1'b0, '0, 1'b0);
      repeat (2) @(posedge clk_i);
      #1;
      vecs++;
      if (pkt_valid_o !== '1) begin
         errs++;
         $display("FAIL rstmid_pre got %h want all ones", pkt_valid_o);
      end
      @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      check_zero_outputs("rstmid");
      for (int n = 0; n < NCH; n++) begin
         exp_q[n].delete();
         exp_ovf[n] = 0;
         obs_ovf[n] = 0;
      end
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      pkt_ready_i = '1;
      fill_beats();
      drive_line(1'b0, 1'b1, -1, 1'b0, '0, 1'b0);
      wait_drain("rstmid");
   endtask

   task automatic test_final_ovf();
      for (int n = 0; n < NCH; n++) begin
         vecs++;
         if (obs_ovf[n] !== exp_ovf[n]) begin
            errs++;
            $display("FAIL final_ovf ch%0d got %0d want %0d", n, obs_ovf[n], exp_ovf[n]);
         end
      end
   endtask

   initial begin
      for (int n = 0; n < NCH; n++) begin
         exp_ovf[n] = 0;
         obs_ovf[n] = 0;
      end
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_zero_header();
      test_backpressure();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_final_ovf();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
